// File: rtl/obi_req_arbiter.sv
// ---------------------------------------------------------------------------
// obi_req_arbiter
//
// Shares one OBI master port between NUM_REQ requesters (for example the
// config memory node and the CGRA input/output memory nodes) in front of the
// system bus crossbar.
//  - Round-robin arbitration. Arbitration is combinational, so a request can
//    be granted in the cycle it first appears.
//  - A request that is presented downstream but not yet granted is locked, so
//    the downstream port sees stable req/addr/we/be/wdata until the grant.
//  - An ID FIFO records the issuer of every accepted transaction, so each
//    in-order response is routed back to the requester that issued it.
//  - err_o is sticky: it is set by an rvalid with no outstanding transaction.
//
// Parameters:
//   NUM_REQ          number of requester ports (2..8)
//   MAX_OUTSTANDING  accepted-but-unanswered transactions allowed (1..4)
//
// Ports:
//   clk_i, rst_ni    clock, asynchronous active-low reset
//   s_req_i/s_we_i   per-requester req and we, one bit per requester
//   s_be_i           per-requester be, requester k at [4k+3:4k]
//   s_addr_i         per-requester addr, requester k at [32k+31:32k]
//   s_wdata_i        per-requester wdata, requester k at [32k+31:32k]
//   s_gnt_o          per-requester gnt (one-hot or zero)
//   s_rvalid_o       per-requester rvalid (one-hot or zero)
//   s_rdata_o        rdata broadcast to all requesters
//   m_*              downstream OBI master port
//   err_o            sticky spurious-response flag
//
// Optional feature, macro OBI_ARB_GRANT_CNT_EN:
//   cnt_clr_i        synchronous clear of all grant counters
//   grant_cnt_o      per-requester saturating 16-bit transaction counters,
//                    requester k at [16k+15:16k]
// ---------------------------------------------------------------------------
module obi_req_arbiter #(
    parameter int NUM_REQ         = 4,
    parameter int MAX_OUTSTANDING = 2
) (
    input  logic                    clk_i,
    input  logic                    rst_ni,
    input  logic [NUM_REQ-1:0]      s_req_i,
    input  logic [NUM_REQ-1:0]      s_we_i,
    input  logic [NUM_REQ*4-1:0]    s_be_i,
    input  logic [NUM_REQ*32-1:0]   s_addr_i,
    input  logic [NUM_REQ*32-1:0]   s_wdata_i,
    output logic [NUM_REQ-1:0]      s_gnt_o,
    output logic [NUM_REQ-1:0]      s_rvalid_o,
    output logic [31:0]             s_rdata_o,
    output logic                    m_req_o,
    output logic                    m_we_o,
    output logic [3:0]              m_be_o,
    output logic [31:0]             m_addr_o,
    output logic [31:0]             m_wdata_o,
    input  logic                    m_gnt_i,
    input  logic                    m_rvalid_i,
    input  logic [31:0]             m_rdata_i,
    output logic                    err_o
`ifdef OBI_ARB_GRANT_CNT_EN
    ,
    input  logic                    cnt_clr_i,
    output logic [NUM_REQ*16-1:0]   grant_cnt_o
`endif
);

    localparam int IDW  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int PTRW = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
    localparam int CNTW = $clog2(MAX_OUTSTANDING + 1);

    localparam logic [CNTW-1:0] MAX_CNT  = CNTW'(MAX_OUTSTANDING);
    localparam logic [IDW-1:0]  LAST_IDX = IDW'(NUM_REQ - 1);
    localparam logic [PTRW-1:0] LAST_PTR = PTRW'(MAX_OUTSTANDING - 1);

    logic [IDW-1:0]  rr_ptr;
    logic            lock;
    logic [IDW-1:0]  locked_idx;
    logic [IDW-1:0]  winner;
    logic [IDW-1:0]  cand;
    logic            found;
    logic            txn;
    logic            pop;
    logic [IDW-1:0]  head;

    logic [IDW-1:0]  fifo_mem [MAX_OUTSTANDING];
    logic [PTRW-1:0] wr_ptr;
    logic [PTRW-1:0] rd_ptr;
    logic [CNTW-1:0] count;

    // Winner: the locked requester if a request is pending downstream,
    // otherwise the first requester at or after rr_ptr. With nobody
    // requesting the winner falls back to requester 0.
    // NOTE: every signal written in always_comb gets a default first, so no
    // path leaves it unassigned and no latch is inferred.
    always_comb begin
        winner = '0;
        cand   = '0;
        found  = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            cand = IDW'((int'(rr_ptr) + i) % NUM_REQ);
            if (!found && s_req_i[cand]) begin
                winner = cand;
                found  = 1'b1;
            end
        end
        if (lock) begin
            winner = locked_idx;
        end
    end

    // Downstream request fields always follow the winner.
    always_comb begin
        m_we_o    = 1'b0;
        m_be_o    = '0;
        m_addr_o  = '0;
        m_wdata_o = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (winner == IDW'(k)) begin
                m_we_o    = s_we_i[k];
                m_be_o    = s_be_i[4*k +: 4];
                m_addr_o  = s_addr_i[32*k +: 32];
                m_wdata_o = s_wdata_i[32*k +: 32];
            end
        end
    end

    // A full FIFO blocks issue even when a response pops in the same cycle.
    assign m_req_o = s_req_i[winner] & (count < MAX_CNT);
    assign txn     = m_req_o & m_gnt_i;
    assign pop     = m_rvalid_i & (count != '0);
    assign head    = fifo_mem[rd_ptr];

    always_comb begin
        s_gnt_o         = '0;
        s_gnt_o[winner] = txn;
    end

    always_comb begin
        s_rvalid_o       = '0;
        s_rvalid_o[head] = pop;
    end

    assign s_rdata_o = m_rdata_i;

    // NOTE: state registers use non-blocking assignments so every flop
    // samples the pre-edge values, independent of block ordering.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rr_ptr     <= '0;
            lock       <= 1'b0;
            locked_idx <= '0;
        end else if (txn) begin
            rr_ptr <= (winner == LAST_IDX) ? '0 : winner + 1'b1;
            lock   <= 1'b0;
        end else if (m_req_o) begin
            // Presented but not granted: hold this requester until accepted.
            lock       <= 1'b1;
            locked_idx <= winner;
        end
    end

    // NOTE: the FIFO storage has no reset; an entry is only read while count
    // says it holds a valid ID, so its power-up contents never matter.
    always_ff @(posedge clk_i) begin
        if (txn) begin
            fifo_mem[wr_ptr] <= winner;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            err_o  <= 1'b0;
        end else begin
            if (txn) begin
                wr_ptr <= (wr_ptr == LAST_PTR) ? '0 : wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= (rd_ptr == LAST_PTR) ? '0 : rd_ptr + 1'b1;
            end
            if (txn && !pop) begin
                count <= count + 1'b1;
            end else if (!txn && pop) begin
                count <= count - 1'b1;
            end
            if (m_rvalid_i && count == '0) begin
                err_o <= 1'b1;
            end
        end
    end

`ifdef OBI_ARB_GRANT_CNT_EN
    logic [15:0] grant_cnt_q [NUM_REQ];

    // Clear wins over increment; counters stick at 16'hFFFF.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int k = 0; k < NUM_REQ; k++) begin
                grant_cnt_q[k] <= '0;
            end
        end else begin
            for (int k = 0; k < NUM_REQ; k++) begin
                if (cnt_clr_i) begin
                    grant_cnt_q[k] <= '0;
                end else if (s_gnt_o[k] && grant_cnt_q[k] != 16'hFFFF) begin
                    grant_cnt_q[k] <= grant_cnt_q[k] + 16'd1;
                end
            end
        end
    end

    always_comb begin
        grant_cnt_o = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            grant_cnt_o[16*k +: 16] = grant_cnt_q[k];
        end
    end
`endif

endmodule
